// File: rtl/mm_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mm_arb_pkg;

  // Arbiter sequencing: every access visits all three states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Which requester currently owns (or last owned) the memory.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_t;

  // Memory latency limits; the latency counter is 4 bits wide.
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int LAT_CNT_W   = 4;

endpackage

// File: rtl/mm_arb_rr.sv
// Two-way round-robin picker: a lone requester always wins, on a tie the
// requester that did not win last time is chosen.
module mm_arb_rr
  import mm_arb_pkg::*;
(
  input  logic   cpu_req,
  input  logic   ld_req,
  input  owner_t last_grant,
  output logic   grant_valid,
  output owner_t grant
);

  // Pick the owner from the current requests and the previous winner.
  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    grant_valid = cpu_req | ld_req;
    grant       = OWN_CPU;
    if (cpu_req && ld_req) begin
      grant = (last_grant == OWN_CPU) ? OWN_LD : OWN_CPU;
    end else if (ld_req) begin
      grant = OWN_LD;
    end
  end

endmodule

// File: rtl/mm_arbiter.sv
// Shares single-port main memory between the CPU and the program loader.
// Each access runs IDLE -> ACCESS (MEM_LAT strobe cycles) -> DONE (ack pulse).
// MEM_LAT must lie in MEM_LAT_MIN..MEM_LAT_MAX.
module mm_arbiter
  import mm_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ack,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT);
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(1);

  state_t                 state_q, state_d;
  owner_t                 owner_q, last_grant_q, grant;
  logic                   grant_valid;
  logic                   cpu_req;
  logic                   take_grant;
  logic                   last_cycle;
  logic [LAT_CNT_W-1:0]   lat_cnt_q;

  // A simultaneous rd and wr from the CPU is treated as a write further down.
  assign cpu_req = cpu_rd | cpu_wr;
  assign busy    = (state_q != IDLE);

  mm_arb_rr u_rr (
    .cpu_req     (cpu_req),
    .ld_req      (ld_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic and the grant / last-strobe-cycle qualifiers.
  always_comb begin
    state_d    = state_q;
    take_grant = 1'b0;
    last_cycle = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          take_grant = 1'b1;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_cnt_q == LAT_LAST) begin
          last_cycle = 1'b1;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes, address/data latches, latency counter, acks and read data.
  // NOTE: the rdata registers are reset because their value is visible to both requesters from reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q      <= OWN_CPU;
      last_grant_q <= OWN_LD;
      lat_cnt_q    <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_ack      <= 1'b0;
      ld_ack       <= 1'b0;
      cpu_rdata    <= '0;
      ld_rdata     <= '0;
    end else begin
      cpu_ack <= 1'b0;
      ld_ack  <= 1'b0;

      if (take_grant) begin
        owner_q      <= grant;
        last_grant_q <= grant;
        lat_cnt_q    <= LAT_LOAD;
        if (grant == OWN_CPU) begin
          mem_addr  <= cpu_addr;
          mem_wdata <= cpu_wdata;
          mem_wr    <= cpu_wr;
          mem_rd    <= ~cpu_wr;
        end else begin
          mem_addr  <= ld_addr;
          mem_wdata <= ld_wdata;
          mem_wr    <= ld_we;
          mem_rd    <= ~ld_we;
        end
      end else if (state_q == ACCESS) begin
        lat_cnt_q <= lat_cnt_q - LAT_LAST;
      end

      // Final strobe cycle: drop strobes, capture read data, schedule the ack.
      if (last_cycle) begin
        mem_rd <= 1'b0;
        mem_wr <= 1'b0;
        if (owner_q == OWN_CPU) begin
          cpu_ack <= 1'b1;
          if (!mem_wr) cpu_rdata <= mem_rdata;
        end else begin
          ld_ack <= 1'b1;
          if (!mem_wr) ld_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
